// File: rtl/spi_sensor_responder.sv
// spi_sensor_responder: SPI mode-0 responder emulating the sensor on the far
// end of the sensor link. SCLK/CS/MOSI are oversampled on clk_i. A host-loaded
// sample is served MSB first on MISO, and the word shifted in on MOSI is
// captured and presented on rx_data_o.
//
// Optional feature: define SPI_RESP_FRAME_CNT_EN to add the 8-bit
// completed-frame counter on frame_cnt_o.
module spi_sensor_responder #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              we_sample_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o
`ifdef SPI_RESP_FRAME_CNT_EN
  ,
  output logic [7:0]        frame_cnt_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Synchronizer stages [1:0] plus edge-detect stage [2].
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    bit_cnt_inc;
`ifdef SPI_RESP_FRAME_CNT_EN
  logic [7:0]          frame_cnt_q, frame_cnt_d;
`endif

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic cs_n_s, mosi_s;

  // Input conditioning: two-flop synchronizers followed by an edge register.
  // NOTE: the synchronizers carry no reset; they only follow the pins, and
  // forcing them would fabricate a CS edge when reset releases with CS low.
  always_ff @(posedge clk_i) begin
    sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
    cs_sync_q   <= {cs_sync_q[1:0], cs_n_i};
    mosi_sync_q <= {mosi_sync_q[0], mosi_i};
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_n_s    = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  // State and datapath registers with synchronous active-high reset.
  // NOTE: non-blocking assignments keep every register sampling the same
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      shadow_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      bit_cnt_q   <= '0;
`ifdef SPI_RESP_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      shadow_q    <= shadow_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      bit_cnt_q   <= bit_cnt_d;
`ifdef SPI_RESP_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  // Next-state logic for the frame FSM and its datapath.
  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    sample_d    = we_sample_i ? sample_i : sample_q;
    shadow_d    = shadow_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    bit_cnt_d   = bit_cnt_q;
`ifdef SPI_RESP_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        // Write bypass: a same-cycle host write is what this frame serves.
        shadow_d  = we_sample_i ? sample_i : sample_q;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          // Abort has priority over a coincident rise; the bit is dropped.
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_inc;
          if (bit_cnt_inc == CNT_W'(DATA_W)) state_d = ST_DONE;
        end else if (sclk_fall && (bit_cnt_q != '0)) begin
          // A fall before the first rise of this frame is the trailing fall of
          // the previous back-to-back frame and must not consume the MSB.
          shadow_d = shadow_q << 1;
        end
      end

      ST_DONE: begin
        rx_data_d   = rx_shift_q;
        rx_valid_d  = 1'b1;
`ifdef SPI_RESP_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q + 8'd1;
`endif
        state_d     = cs_n_s ? ST_IDLE : ST_LOAD;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign miso_oe_o  = (state_q != ST_IDLE);
  assign miso_o     = miso_oe_o & shadow_q[DATA_W-1];
  assign busy_o     = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
`ifdef SPI_RESP_FRAME_CNT_EN
  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Self-checking bench for spi_sensor_responder: a behavioural SPI mode-0
// master drives frames; expected MOSI words go to a scoreboard queue and are
// checked on every rx_valid_o pulse, MISO words are checked per frame.
`timescale 1ns/1ps
module tb_spi_sensor_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk, cs_n, mosi;
  logic        miso, miso_oe;
  logic [15:0] sample;
  logic        we_sample;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
`ifdef SPI_RESP_FRAME_CNT_EN
  logic [7:0]  frame_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          half_clk = 5;
  logic [15:0] exp_rx_q[$];

  always #50 clk = ~clk;

  spi_sensor_responder #(.DATA_W(16)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .sclk_i      (sclk),
    .cs_n_i      (cs_n),
    .mosi_i      (mosi),
    .miso_o      (miso),
    .miso_oe_o   (miso_oe),
    .sample_i    (sample),
    .we_sample_i (we_sample),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .busy_o      (busy)
`ifdef SPI_RESP_FRAME_CNT_EN
    ,
    .frame_cnt_o (frame_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every rx_valid_o cycle must match the oldest word.
  always @(negedge clk) begin
    if (!reset && rx_valid) begin
      if (exp_rx_q.size() == 0) chk("unexpected_rx_valid", {31'd0, rx_valid}, 32'd0);
      else                      chk("rx_data", {16'd0, rx_data}, {16'd0, exp_rx_q.pop_front()});
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input logic [15:0] v);
    sample    = v;
    we_sample = 1'b1;
    wait_clk(1);
    we_sample = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  // Mode 0: MOSI changes while SCLK is low, MISO is sampled just before rise.
  task automatic spi_bits(input logic [15:0] tx, input int n, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[15-i];
      wait_clk(half_clk);
      got  = {got[14:0], miso};
      sclk = 1'b1;
      wait_clk(half_clk);
      sclk = 1'b0;
    end
  endtask

  task automatic full_frame(input string tag, input logic [15:0] tx, input logic [15:0] exp_miso);
    logic [15:0] got;
    exp_rx_q.push_back(tx);
    cs_low();
    spi_bits(tx, 16, got);
    cs_high();
    chk(tag, {16'd0, got}, {16'd0, exp_miso});
    chk({tag, "_rx_pending"}, exp_rx_q.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] g1, g2;
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    sample = '0; we_sample = 1'b0;
    wait_clk(5);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_rx_data", {16'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_RESP_FRAME_CNT_EN
    chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
`endif
    reset = 1'b0;
    wait_clk(5);

    // Basic read.
    write_sample(16'h0A5C);
    full_frame("basic_miso", 16'h1234, 16'h0A5C);
    chk("basic_rx_hold", {16'd0, rx_data}, 32'h1234);

    // Host write mid-frame must not disturb the frame in flight.
    exp_rx_q.push_back(16'hA5F0);
    cs_low();
    spi_bits(16'hA5F0, 5, g1);
    write_sample(16'hFFFF);
    spi_bits(16'hA5F0 << 5, 11, g2);
    cs_high();
    chk("wr_mid_miso", {16'd0, g1[4:0], g2[10:0]}, 32'h0A5C);
    full_frame("wr_next_miso", 16'h00FF, 16'hFFFF);

    // Abort after 7 rises: nothing delivered, outputs released.
    cs_low();
    spi_bits(16'h7E81, 7, g1);
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(5);
    chk("abort_oe", {31'd0, miso_oe}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_miso", {31'd0, miso}, 32'd0);
    chk("abort_rx_hold", {16'd0, rx_data}, 32'h00FF);
    wait_clk(8);
    full_frame("post_abort_miso", 16'h8001, 16'hFFFF);

    // Back-to-back frames under one CS.
    write_sample(16'hBEEF);
    exp_rx_q.push_back(16'hC3C3);
    exp_rx_q.push_back(16'h0F0F);
    cs_low();
    spi_bits(16'hC3C3, 16, g1);
    spi_bits(16'h0F0F, 16, g2);
    cs_high();
    chk("b2b_miso_0", {16'd0, g1}, 32'hBEEF);
    chk("b2b_miso_1", {16'd0, g2}, 32'hBEEF);
    chk("b2b_rx_pending", exp_rx_q.size(), 32'd0);

    // Reset at bit 9.
    cs_low();
    spi_bits(16'h3C3C, 9, g1);
    reset = 1'b1;
    wait_clk(1);
    chk("mid_rst_miso", {31'd0, miso}, 32'd0);
    chk("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("mid_rst_rx_data", {16'd0, rx_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_RESP_FRAME_CNT_EN
    chk("mid_rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
`endif
    wait_clk(2);
    reset = 1'b0;
    cs_n  = 1'b1;
    wait_clk(8);
    chk("post_rst_oe", {31'd0, miso_oe}, 32'd0);
    write_sample(16'h5A5A);
    full_frame("post_rst_miso", 16'h9999, 16'h5A5A);

`ifdef SPI_RESP_FRAME_CNT_EN
    // 257 complete frames since reset plus one abort leaves the counter at 1.
    half_clk = 4;
    for (int i = 0; i < 256; i++) full_frame("cnt_miso", 16'(i * 16'h0101 + 3), 16'h5A5A);
    cs_low();
    spi_bits(16'h1111, 7, g1);
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(10);
    chk("frame_cnt_wrap", {24'd0, frame_cnt}, 32'd1);
    half_clk = 5;
`endif

    wait_clk(20);
    chk("scoreboard_empty", exp_rx_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
